// File: rtl/bp_pkg.sv
// Shared types for the perceptron B-predictor training scheduler:
// FSM states, weight-row packing, saturation bounds, resolution entry.
package bp_pkg;

  localparam int W_WIDTH  = 8;
  localparam int HIST_LEN = 8;
  localparam int BIAS_OFS = 64;
  localparam int ROW_W    = 72;

  localparam logic [7:0] W_MAX = 8'h7F;
  localparam logic [7:0] W_MIN = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_FLUSH   = 3'd4
  } state_t;

  typedef struct packed {
    logic [1:0]  slot;
    logic        taken;
    logic [7:0]  hist;
    logic [10:0] sum;
    logic        mispredict;
  } res_t;

  // One saturating +/-1 step of a signed 8-bit weight.
  function automatic logic [7:0] sat_step(
    input logic [7:0] w,
    input logic       up
  );
    logic [7:0] r;
    r = w;
    if (up && (w != W_MAX)) r = w + 8'd1;
    else if (!up && (w != W_MIN)) r = w - 8'd1;
    return r;
  endfunction

endpackage

// File: rtl/perceptron_row_update.sv
// Combinational saturating perceptron update of one 72-bit weight row.
// Ports: i_row_72 old row, i_taken outcome, i_hist_8 GHR bits, o_row_72 new row.
module perceptron_row_update
  import bp_pkg::*;
(
  input  logic [ROW_W-1:0] i_row_72,
  input  logic             i_taken,
  input  logic [7:0]       i_hist_8,
  output logic [ROW_W-1:0] o_row_72
);

  always_comb begin
    o_row_72 = i_row_72;
    for (int j = 0; j < HIST_LEN; j++) begin
      o_row_72[j*W_WIDTH +: W_WIDTH] =
        sat_step(i_row_72[j*W_WIDTH +: W_WIDTH],
                 i_hist_8[j] == i_taken);
    end
    o_row_72[BIAS_OFS +: W_WIDTH] =
      sat_step(i_row_72[BIAS_OFS +: W_WIDTH], i_taken);
  end

endmodule

// File: rtl/perceptron_train_scheduler.sv
// Perceptron training scheduler: resolution FIFO, RMW of the weight table
// through a req/gnt port, pending-B counter and mispredict flush.
// Ports: i_res* resolution push (o_resReady), i_issue* pending increments,
// o_wt*/i_wt* table access, o_pendingB_8, o_flush, o_busy.
// Option: PERCEPTRON_WB_FORWARD_EN forwards the last written row.
module perceptron_train_scheduler #(
  parameter int FIFO_DEPTH = 8,
  parameter int HIST_LEN   = 8,
  parameter int W_WIDTH    = 8,
  parameter int THETA      = 15
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_resValid,
  output logic        o_resReady,
  input  logic [1:0]  i_resSlot_2,
  input  logic        i_resTaken,
  input  logic [7:0]  i_resHist_8,
  input  logic [10:0] i_resSum_11,
  input  logic        i_resMispredict,
  input  logic        i_issueValid,
  input  logic [2:0]  i_issueNum_3,
  output logic        o_wtReq,
  input  logic        i_wtGnt,
  output logic        o_wtWe,
  output logic [1:0]  o_wtRow_2,
  output logic [71:0] o_wtWdata_72,
  input  logic [71:0] i_wtRdata_72,
  output logic [7:0]  o_pendingB_8,
  output logic        o_flush,
  output logic        o_busy
);
  import bp_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int ROW_BITS = (HIST_LEN + 1) * W_WIDTH;
  localparam logic [AW:0] PTR_ONE = 1;

  state_t r_state;
  state_t w_state_nxt;

  res_t        r_mem [FIFO_DEPTH];
  logic [AW:0] r_wp;
  logic [AW:0] r_rp;
  logic [7:0]  r_pend;
  logic [ROW_BITS-1:0] r_row;

  res_t        w_entry;
  res_t        w_head;
  logic        w_empty;
  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic [10:0] w_abs;
  logic        w_need;
  logic        w_fwd_hit;
  logic        w_fwd_load;
  logic [ROW_BITS-1:0] w_fwd_row;
  logic [ROW_BITS-1:0] w_upd;
  logic [9:0]  w_pend_add;
  logic [9:0]  w_pend_sub;
  logic [7:0]  w_pend_nxt;

  assign w_entry = {i_resSlot_2, i_resTaken, i_resHist_8,
                    i_resSum_11, i_resMispredict};
  assign w_head  = r_mem[r_rp[AW-1:0]];
  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[AW] != r_rp[AW]) &&
                   (r_wp[AW-1:0] == r_rp[AW-1:0]);

  // A full FIFO still accepts when the head leaves this same cycle.
  assign o_resReady = (!w_full || w_pop) && (r_state != ST_FLUSH);
  assign w_push     = i_resValid && o_resReady;

  assign w_abs  = w_head.sum[10] ? (~w_head.sum + 11'd1) : w_head.sum;
  assign w_need = w_head.mispredict || (w_abs <= 11'(THETA));

`ifdef PERCEPTRON_WB_FORWARD_EN
  logic                r_fwd_vld;
  logic [1:0]          r_fwd_idx;
  logic [ROW_BITS-1:0] r_fwd_row;

  assign w_fwd_hit = r_fwd_vld && (r_fwd_idx == w_head.slot);
  assign w_fwd_row = r_fwd_row;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fwd_vld <= 1'b0;
      r_fwd_idx <= '0;
      r_fwd_row <= '0;
    end else if (r_state == ST_FLUSH) begin
      r_fwd_vld <= 1'b0;
    end else if ((r_state == ST_WR_REQ) && i_wtGnt) begin
      r_fwd_vld <= 1'b1;
      r_fwd_idx <= w_head.slot;
      r_fwd_row <= w_upd;
    end
  end
`else
  assign w_fwd_hit = 1'b0;
  assign w_fwd_row = '0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_fwd_load  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          if (!w_need) begin
            w_pop = 1'b1;
          end else if (w_fwd_hit) begin
            w_fwd_load  = 1'b1;
            w_state_nxt = ST_WR_REQ;
          end else begin
            w_state_nxt = ST_RD_REQ;
          end
        end
      end
      ST_RD_REQ: begin
        if (i_wtGnt) w_state_nxt = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        w_state_nxt = ST_WR_REQ;
      end
      ST_WR_REQ: begin
        if (i_wtGnt) begin
          w_pop       = 1'b1;
          w_state_nxt = w_head.mispredict ? ST_FLUSH : ST_IDLE;
        end
      end
      ST_FLUSH: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Issue and resolve combine before clamping so 254+4-1 lands on 255.
  assign w_pend_add = {2'b00, r_pend} +
                      (i_issueValid ? {7'd0, i_issueNum_3} : 10'd0);
  assign w_pend_sub = (w_push && (w_pend_add != 10'd0)) ?
                      (w_pend_add - 10'd1) : w_pend_add;
  assign w_pend_nxt = (w_pend_sub > 10'd255) ? 8'hFF : w_pend_sub[7:0];

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= w_entry;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_wp    <= '0;
      r_rp    <= '0;
      r_pend  <= '0;
      r_row   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) r_wp <= r_wp + PTR_ONE;
      // Entries behind a mispredict are wrong-path: drop them all.
      if (r_state == ST_FLUSH) r_rp <= r_wp;
      else if (w_pop) r_rp <= r_rp + PTR_ONE;
      r_pend <= (r_state == ST_FLUSH) ? 8'd0 : w_pend_nxt;
      if (r_state == ST_RD_WAIT) r_row <= i_wtRdata_72;
      else if (w_fwd_load) r_row <= w_fwd_row;
    end
  end

  perceptron_row_update u_upd (
    .i_row_72 (r_row),
    .i_taken  (w_head.taken),
    .i_hist_8 (w_head.hist),
    .o_row_72 (w_upd)
  );

  assign o_wtReq      = (r_state == ST_RD_REQ) || (r_state == ST_WR_REQ);
  assign o_wtWe       = (r_state == ST_WR_REQ);
  assign o_wtRow_2    = o_wtReq ? w_head.slot : 2'd0;
  assign o_wtWdata_72 = (r_state == ST_WR_REQ) ? w_upd : 72'd0;
  assign o_pendingB_8 = r_pend;
  assign o_flush      = (r_state == ST_FLUSH);
  assign o_busy       = (r_state != ST_IDLE) || !w_empty;

endmodule

// File: tb/tb_perceptron_train_scheduler.sv
// Self-checking bench for perceptron_train_scheduler with a behavioural
// single-port weight table answering the req/gnt port.
module tb_perceptron_train_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        resValid;
  logic        resReady;
  logic [1:0]  resSlot;
  logic        resTaken;
  logic [7:0]  resHist;
  logic [10:0] resSum;
  logic        resMisp;
  logic        issueValid;
  logic [2:0]  issueNum;
  logic        wtReq;
  logic        gnt;
  logic        wtWe;
  logic [1:0]  wtRow;
  logic [71:0] wtWdata;
  logic [71:0] rdata;
  logic [7:0]  pend;
  logic        flush;
  logic        busy;

  always #5 clk = ~clk;

  perceptron_train_scheduler dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_resValid     (resValid),
    .o_resReady     (resReady),
    .i_resSlot_2    (resSlot),
    .i_resTaken     (resTaken),
    .i_resHist_8    (resHist),
    .i_resSum_11    (resSum),
    .i_resMispredict(resMisp),
    .i_issueValid   (issueValid),
    .i_issueNum_3   (issueNum),
    .o_wtReq        (wtReq),
    .i_wtGnt        (gnt),
    .o_wtWe         (wtWe),
    .o_wtRow_2      (wtRow),
    .o_wtWdata_72   (wtWdata),
    .i_wtRdata_72   (rdata),
    .o_pendingB_8   (pend),
    .o_flush        (flush),
    .o_busy         (busy)
  );

  logic [71:0] mem [4];
  logic        pre_en;
  logic [1:0]  pre_slot;
  logic [71:0] pre_val;
  int n_wr = 0;
  int n_rd = 0;
  int n_fl = 0;
  int n_rq = 0;
  int n_chk = 0;
  int n_err = 0;

  always @(posedge clk) begin
    if (pre_en) mem[pre_slot] <= pre_val;
    if (wtReq && gnt) begin
      if (wtWe) begin
        mem[wtRow] <= wtWdata;
        n_wr <= n_wr + 1;
      end else begin
        rdata <= mem[wtRow];
        n_rd <= n_rd + 1;
      end
    end
    if (flush) n_fl <= n_fl + 1;
    if (wtReq) n_rq <= n_rq + 1;
  end

  typedef struct {
    logic [1:0]  slot;
    logic        taken;
    logic [7:0]  hist;
    logic [10:0] sum;
    logic [71:0] init;
    logic [71:0] exp;
    int          wr;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string nm, input logic [71:0] act,
                     input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [1:0] s, input logic [71:0] v);
    @(negedge clk);
    pre_slot = s;
    pre_val  = v;
    pre_en   = 1'b1;
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  task automatic push(input logic [1:0] s, input logic t,
                      input logic [7:0] h, input logic [10:0] sm,
                      input logic m);
    @(negedge clk);
    resSlot  = s;
    resTaken = t;
    resHist  = h;
    resSum   = sm;
    resMisp  = m;
    resValid = 1'b1;
    @(posedge clk);
    #1 resValid = 1'b0;
  endtask

  task automatic issue(input logic [2:0] n);
    @(negedge clk);
    issueValid = 1'b1;
    issueNum   = n;
    @(posedge clk);
    #1 issueValid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (busy && (k < 40)) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 72'(k < 40), 72'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int r0;
    int f0;
    int q0;
    rst_n = 1'b0;
    resValid = 1'b0;
    resSlot = '0;
    resTaken = 1'b0;
    resHist = '0;
    resSum = '0;
    resMisp = 1'b0;
    issueValid = 1'b0;
    issueNum = '0;
    gnt = 1'b1;
    pre_en = 1'b0;
    pre_slot = '0;
    pre_val = '0;
    rdata = '0;

    vt[0] = '{2'd0, 1'b0, 8'h00, 11'd15,
              72'h80_00_00_00_00_00_00_00_7F,
              72'h80_01_01_01_01_01_01_01_7F, 1};
    vt[1] = '{2'd2, 1'b1, 8'h00, 11'd200,
              72'h05_05_05_05_05_05_05_05_05,
              72'h05_05_05_05_05_05_05_05_05, 0};
    vt[2] = '{2'd3, 1'b1, 8'hA5, 11'h7FB,
              72'h10_10_10_10_10_10_10_10_10,
              72'h11_11_0F_11_0F_0F_11_0F_11, 1};
    vt[3] = '{2'd1, 1'b1, 8'h00, 11'd16,
              72'h0, 72'h0, 0};
    vt[4] = '{2'd1, 1'b1, 8'h00, 11'h7F1,
              72'h0,
              72'h01_FF_FF_FF_FF_FF_FF_FF_FF, 1};
    vt[5] = '{2'd0, 1'b1, 8'h00, 11'h7F0,
              72'h33_33_33_33_33_33_33_33_33,
              72'h33_33_33_33_33_33_33_33_33, 0};
    vt[6] = '{2'd2, 1'b1, 8'h00, 11'd0,
              72'h7F_80_80_80_80_80_80_80_80,
              72'h7F_80_80_80_80_80_80_80_80, 1};
    vt[7] = '{2'd0, 1'b1, 8'h00, 11'h400,
              72'h0, 72'h0, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 72'(resReady), 72'd1);
    chk("rst_req", 72'(wtReq), 72'd0);
    chk("rst_we", 72'(wtWe), 72'd0);
    chk("rst_row", 72'(wtRow), 72'd0);
    chk("rst_wdata", wtWdata, 72'd0);
    chk("rst_pend", 72'(pend), 72'd0);
    chk("rst_flush", 72'(flush), 72'd0);
    chk("rst_busy", 72'(busy), 72'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Latency with immediate grants.
    preload(2'd1, 72'd0);
    push(2'd1, 1'b1, 8'hFF, 11'd3, 1'b0);
    chk("lat_n0_req", 72'(wtReq), 72'd0);
    @(posedge clk); #1;
    chk("lat_rd", 72'({wtReq, wtWe, wtRow}), 72'({1'b1, 1'b0, 2'd1}));
    @(posedge clk); #1;
    chk("lat_wait_req", 72'(wtReq), 72'd0);
    @(posedge clk); #1;
    chk("lat_wr", 72'({wtReq, wtWe, wtRow}), 72'({1'b1, 1'b1, 2'd1}));
    chk("lat_wdata", wtWdata, 72'h01_01_01_01_01_01_01_01_01);
    @(posedge clk); #1;
    chk("lat_end", 72'({wtReq, flush, busy}), 72'd0);
    chk("lat_mem", mem[1], 72'h01_01_01_01_01_01_01_01_01);

    for (int i = 0; i < 8; i++) begin
      preload(vt[i].slot, vt[i].init);
      w0 = n_wr;
      push(vt[i].slot, vt[i].taken, vt[i].hist, vt[i].sum, 1'b0);
      wait_idle($sformatf("v%0d_done", i));
      chk($sformatf("v%0d_row", i), mem[vt[i].slot], vt[i].exp);
      chk($sformatf("v%0d_wr", i), 72'(n_wr - w0), 72'(vt[i].wr));
      chk($sformatf("v%0d_pend", i), 72'(pend), 72'd0);
    end

    // No-train pop and pending decrement.
    issue(3'd4);
    issue(3'd1);
    chk("nt_pend5", 72'(pend), 72'd5);
    q0 = n_rq;
    push(2'd2, 1'b1, 8'h00, 11'd200, 1'b0);
    chk("nt_pend4", 72'(pend), 72'd4);
    chk("nt_busy", 72'(busy), 72'd1);
    @(posedge clk); #1;
    chk("nt_popped", 72'(busy), 72'd0);
    chk("nt_noreq", 72'(n_rq - q0), 72'd0);

    // Grant stall during read request.
    preload(2'd3, 72'd0);
    gnt = 1'b0;
    push(2'd3, 1'b1, 8'hFF, 11'd0, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("stall%0d", i), 72'({wtReq, wtWe, wtRow}),
          72'({1'b1, 1'b0, 2'd3}));
      @(posedge clk); #1;
    end
    gnt = 1'b1;
    @(posedge clk); #1;
    chk("stall_wait", 72'(wtReq), 72'd0);
    @(posedge clk); #1;
    chk("stall_wr", 72'({wtReq, wtWe}), 72'd3);
    wait_idle("stall_done");
    chk("stall_mem", mem[3], 72'h01_01_01_01_01_01_01_01_01);
    chk("stall_pend", 72'(pend), 72'd3);

    // Mispredict followed by wrong-path entries.
    issue(3'd4);
    issue(3'd4);
    gnt = 1'b0;
    preload(2'd0, 72'd0);
    push(2'd0, 1'b0, 8'h00, 11'd100, 1'b1);
    for (int i = 0; i < 3; i++) push(2'd1, 1'b1, 8'hFF, 11'd3, 1'b0);
    chk("mp_pend7", 72'(pend), 72'd7);
    w0 = n_wr;
    r0 = n_rd;
    f0 = n_fl;
    gnt = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (flush) chk("mp_flush_ready", 72'(resReady), 72'd0);
    end
    chk("mp_flushes", 72'(n_fl - f0), 72'd1);
    chk("mp_writes", 72'(n_wr - w0), 72'd1);
    chk("mp_reads", 72'(n_rd - r0), 72'd1);
    chk("mp_pend0", 72'(pend), 72'd0);
    chk("mp_busy", 72'(busy), 72'd0);
    chk("mp_ready", 72'(resReady), 72'd1);
    chk("mp_mem", mem[0], 72'hFF_01_01_01_01_01_01_01_01);

    // Pending saturation at 255.
    for (int i = 0; i < 63; i++) issue(3'd4);
    issue(3'd2);
    chk("sat_254", 72'(pend), 72'd254);
    @(negedge clk);
    issueValid = 1'b1;
    issueNum = 3'd4;
    resSlot = 2'd1;
    resTaken = 1'b1;
    resHist = 8'h00;
    resSum = 11'd200;
    resMisp = 1'b0;
    resValid = 1'b1;
    @(posedge clk);
    #1;
    issueValid = 1'b0;
    resValid = 1'b0;
    chk("sat_255", 72'(pend), 72'd255);
    issue(3'd4);
    chk("sat_hold", 72'(pend), 72'd255);
    wait_idle("sat_done");

    // Fill the FIFO behind a stalled read.
    gnt = 1'b0;
    for (int i = 0; i < 8; i++) push(2'd2, 1'b1, 8'h00, 11'd0, 1'b0);
    chk("full_ready", 72'(resReady), 72'd0);
    chk("full_pend", 72'(pend), 72'd247);
    push(2'd2, 1'b1, 8'h00, 11'd0, 1'b0);
    chk("full_reject", 72'(pend), 72'd247);
    chk("full_req", 72'(wtReq), 72'd1);

    // Asynchronous reset mid-access.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", 72'({wtReq, wtWe}), 72'd0);
    chk("arst_ready", 72'(resReady), 72'd1);
    chk("arst_pend", 72'(pend), 72'd0);
    chk("arst_busy", 72'(busy), 72'd0);
    @(negedge clk);
    rst_n = 1'b1;
    gnt = 1'b1;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
